// File: rtl/ifetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_stage_pkg
//   Shared pipeline constants for the PC unit and the instruction-fetch stage:
//   fetch FSM state encoding, the bubble instruction and the fixed vectors.
// ---------------------------------------------------------------------------
package ifetch_stage_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,   // no fetch outstanding
      S_WAIT   = 2'd1,   // request out, waiting for ack
      S_SQUASH = 2'd2,   // request out but flushed; ack data will be dropped
      S_HOLD   = 2'd3    // word received while ID stalled; parked in skid buffer
   } fetch_state_e;

   localparam logic [31:0] IF_NOP_INSTR  = 32'h0000_0000;
   localparam logic [31:0] RESET_VECTOR  = 32'h8000_0000;
   localparam logic [31:0] EXC_VECTOR_0  = 32'h8000_0004;
   localparam logic [31:0] EXC_VECTOR_1  = 32'h8000_0008;

endpackage

// File: rtl/ifetch_stage_if.sv
// ---------------------------------------------------------------------------
// ifetch_stage_if
//   Instruction-memory request/ack bus.
//   master : fetch stage  (drives IMem_Req/IMem_Addr, receives IMem_Ack/IMem_Rdata)
//   slave  : memory side  (the reverse)
//   IMem_Ack is a one-cycle pulse qualifying IMem_Rdata.
// ---------------------------------------------------------------------------
interface ifetch_stage_if #(
   parameter int XLEN = 32
);
   logic            IMem_Req;
   logic [XLEN-1:0] IMem_Addr;
   logic            IMem_Ack;
   logic [XLEN-1:0] IMem_Rdata;

   modport master (output IMem_Req, IMem_Addr, input  IMem_Ack, IMem_Rdata);
   modport slave  (input  IMem_Req, IMem_Addr, output IMem_Ack, IMem_Rdata);
endinterface

// File: rtl/ifetch_stage_skid_buffer.sv
// ---------------------------------------------------------------------------
// if_skid_buffer
//   Parks one fetched word (instruction, PC+4, supervisor bit) when memory
//   acks while ID is stalled.
//   CLK, Reset_n        : clock, async active-low reset
//   load_i              : capture instr_i/pc4_i/super_i
//   clear_i             : empty the buffer (takes priority over load_i)
//   instr_o/pc4_o/super_o : buffered contents
// ---------------------------------------------------------------------------
module if_skid_buffer #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            Reset_n,
   input  logic            load_i,
   input  logic            clear_i,
   input  logic [XLEN-1:0] instr_i,
   input  logic [XLEN-1:0] pc4_i,
   input  logic            super_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc4_o,
   output logic            super_o
);

   logic [XLEN-1:0] instr_q, pc4_q;
   logic            super_q;

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         instr_q <= '0;
         pc4_q   <= '0;
         super_q <= 1'b0;
      end else if (clear_i) begin
         instr_q <= '0;
         pc4_q   <= '0;
         super_q <= 1'b0;
      end else if (load_i) begin
         instr_q <= instr_i;
         pc4_q   <= pc4_i;
         super_q <= super_i;
      end
   end

   assign instr_o = instr_q;
   assign pc4_o   = pc4_q;
   assign super_o = super_q;

endmodule

// File: rtl/ifetch_stage.sv
// ---------------------------------------------------------------------------
// ifetch_stage
//   Instruction fetch: issues one IMem request per PC, loads the IF/ID
//   register, and tells the PC unit to hold while a fetch is outstanding.
//   CLK, Reset_n     : clock, async active-low reset
//   PC, PCplus4, Super : current PC, PC+4 and supervisor bit from the PC unit
//   IF_Stall         : ID cannot accept a new instruction
//   IF_Flush         : wrong-path; PC unit loads the redirect target this cycle
//   imem             : request/ack bus to instruction memory (master side)
//   Fetch_Busy       : combinational PC-hold request
//   ID_Instr, ID_PCplus4, ID_Super, ID_Valid : IF/ID pipeline register
// ---------------------------------------------------------------------------
module ifetch_stage
   import ifetch_stage_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(IF_NOP_INSTR)
) (
   input  logic                 CLK,
   input  logic                 Reset_n,
   input  logic [XLEN-1:0]      PC,
   input  logic [XLEN-1:0]      PCplus4,
   input  logic                 Super,
   input  logic                 IF_Stall,
   input  logic                 IF_Flush,
   ifetch_stage_if.master       imem,
   output logic                 Fetch_Busy,
   output logic [XLEN-1:0]      ID_Instr,
   output logic [XLEN-1:0]      ID_PCplus4,
   output logic                 ID_Super,
   output logic                 ID_Valid
);

   fetch_state_e    state_q, state_d;
   logic            req_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] pend_pc4_q;
   logic            pend_super_q;

   logic [XLEN-1:0] skid_instr, skid_pc4;
   logic            skid_super;

   logic ack;
   logic issue;
   logic deliver_mem;
   logic deliver_buf;
   logic skid_load;
   logic skid_clear;

   // Ack is only meaningful while a request is outstanding; IDLE/HOLD never look at it.
   assign ack         = imem.IMem_Ack;
   assign issue       = (state_q == S_IDLE) && !IF_Stall && !IF_Flush;
   assign deliver_mem = (state_q == S_WAIT) && ack && !IF_Stall && !IF_Flush;
   assign deliver_buf = (state_q == S_HOLD) && !IF_Stall && !IF_Flush;
   assign skid_load   = (state_q == S_WAIT) && ack && IF_Stall && !IF_Flush;
   // Empty the buffer on any exit from HOLD, whether delivered or flushed.
   assign skid_clear  = (state_q == S_HOLD) && (IF_Flush || !IF_Stall);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (issue) state_d = S_WAIT;
         S_WAIT: begin
            if (IF_Flush)      state_d = ack ? S_IDLE : S_SQUASH;
            else if (ack)      state_d = IF_Stall ? S_HOLD : S_IDLE;
         end
         S_SQUASH: if (ack) state_d = S_IDLE;   // flush here is already covered
         S_HOLD:   if (IF_Flush || !IF_Stall) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Busy drops in any cycle where the PC unit must move: the redirect cycle
   // of a flush, or the cycle the fetched word enters ID.
   always_comb begin
      Fetch_Busy = 1'b0;
      case (state_q)
         S_IDLE:   Fetch_Busy = issue;
         S_WAIT:   Fetch_Busy = !IF_Flush && !(ack && !IF_Stall);
         S_SQUASH: Fetch_Busy = 1'b1;
         S_HOLD:   Fetch_Busy = !IF_Flush && IF_Stall;
         default:  Fetch_Busy = 1'b0;
      endcase
   end

   // ---------------- request / pending registers ----------------
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         req_q        <= 1'b0;
         addr_q       <= '0;
         pend_pc4_q   <= '0;
         pend_super_q <= 1'b0;
      end else begin
         req_q <= (state_d == S_WAIT) || (state_d == S_SQUASH);
         if (issue) begin
            addr_q       <= PC;
            pend_pc4_q   <= PCplus4;
            pend_super_q <= Super;
         end
      end
   end

   assign imem.IMem_Req  = req_q;
   assign imem.IMem_Addr = addr_q;

   if_skid_buffer #(.XLEN(XLEN)) u_skid (
      .CLK     (CLK),
      .Reset_n (Reset_n),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .instr_i (imem.IMem_Rdata),
      .pc4_i   (pend_pc4_q),
      .super_i (pend_super_q),
      .instr_o (skid_instr),
      .pc4_o   (skid_pc4),
      .super_o (skid_super)
   );

   // ---------------- IF/ID register ----------------
   // Flush beats stall; a bubble keeps PC+4/super so only Instr/Valid change.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         ID_Instr   <= NOP_INSTR;
         ID_PCplus4 <= '0;
         ID_Super   <= 1'b0;
         ID_Valid   <= 1'b0;
      end else if (IF_Flush) begin
         ID_Instr <= NOP_INSTR;
         ID_Valid <= 1'b0;
      end else if (IF_Stall) begin
         // hold
      end else if (deliver_mem) begin
         ID_Instr   <= imem.IMem_Rdata;
         ID_PCplus4 <= pend_pc4_q;
         ID_Super   <= pend_super_q;
         ID_Valid   <= 1'b1;
      end else if (deliver_buf) begin
         ID_Instr   <= skid_instr;
         ID_PCplus4 <= skid_pc4;
         ID_Super   <= skid_super;
         ID_Valid   <= 1'b1;
      end else begin
         ID_Instr <= NOP_INSTR;
         ID_Valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ifetch_stage.sv
module tb_ifetch_stage;

   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        CLK = 1'b0;
   logic        Reset_n = 1'b0;
   logic [31:0] PC = RST_PC;
   logic [31:0] PCplus4 = RST_PC + 32'd4;
   logic        Super = 1'b1;
   logic        IF_Stall = 1'b1;
   logic        IF_Flush = 1'b0;
   logic        Fetch_Busy;
   logic [31:0] ID_Instr, ID_PCplus4;
   logic        ID_Super, ID_Valid;

   ifetch_stage_if #(.XLEN(32)) imem ();

   ifetch_stage #(.XLEN(32), .NOP_INSTR(NOP)) dut (
      .CLK        (CLK),
      .Reset_n    (Reset_n),
      .PC         (PC),
      .PCplus4    (PCplus4),
      .Super      (Super),
      .IF_Stall   (IF_Stall),
      .IF_Flush   (IF_Flush),
      .imem       (imem),
      .Fetch_Busy (Fetch_Busy),
      .ID_Instr   (ID_Instr),
      .ID_PCplus4 (ID_PCplus4),
      .ID_Super   (ID_Super),
      .ID_Valid   (ID_Valid)
   );

   always #5 CLK = ~CLK;

   // expected view of the DUT for one clock: busy before the edge, the rest after it
   typedef struct {
      logic        busy;
      logic        req;
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        sup;
      logic        vld;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // stimulus knobs: force < 0 means random with the given percentage
   int          st_force = 0, fl_force = 0, wait_fix = 0;
   int unsigned st_pct = 25, fl_pct = 7, spur_pct = 0;
   bit          data_fix_en = 0, tgt_fix_en = 0;
   logic [31:0] data_fix = 0, tgt_fix = 0, redirect = 0;

   // memory responder
   bit mem_armed = 0, mem_done = 0;
   int mem_cnt = 0;

   // reference model: one transaction slot (0 none, 1 in flight, 2 word parked, 3 killed in flight)
   int          tx = 0;
   logic [31:0] pc_nx = RST_PC, tx_addr = 0, tx_pc4 = 0, tx_data = 0;
   logic        tx_sup = 0;
   logic [31:0] m_instr = NOP, m_pc4 = 0;
   logic        m_sup = 0, m_vld = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      tx = 0; tx_addr = 0; tx_pc4 = 0; tx_data = 0; tx_sup = 0;
      m_instr = NOP; m_pc4 = 0; m_sup = 0; m_vld = 0;
      pc_nx = RST_PC; mem_armed = 0; mem_done = 0;
   endtask

   // Applies the fetch rules to the inputs seen this cycle, producing the
   // expected busy now and the expected bus/ID contents after the edge.
   task automatic model_step();
      exp_t        e;
      logic        s, f, a, busy, dlv;
      logic [31:0] d;
      s = IF_Stall; f = IF_Flush; a = imem.IMem_Ack; d = imem.IMem_Rdata;
      busy = 1'b0; dlv = 1'b0;
      case (tx)
         0: if (!s && !f) begin
               busy = 1'b1; tx = 1;
               tx_addr = PC; tx_pc4 = PCplus4; tx_sup = Super;
            end
         1: if (f) tx = a ? 0 : 3;
            else if (a) begin
               tx_data = d;
               if (s) begin busy = 1'b1; tx = 2; end
               else   begin dlv = 1'b1; tx = 0; end
            end else busy = 1'b1;
         2: if (f) tx = 0;
            else if (!s) begin dlv = 1'b1; tx = 0; end
            else busy = 1'b1;
         default: begin busy = 1'b1; if (a) tx = 0; end
      endcase
      if (f) begin
         m_instr = NOP; m_vld = 1'b0;
      end else if (!s) begin
         if (dlv) begin m_instr = tx_data; m_pc4 = tx_pc4; m_sup = tx_sup; m_vld = 1'b1; end
         else     begin m_instr = NOP; m_vld = 1'b0; end
      end
      if (f)                pc_nx = redirect;
      else if (!busy && !s) pc_nx = PC + 32'd4;
      e = '{busy: busy, req: (tx == 1 || tx == 3), addr: tx_addr,
            instr: m_instr, pc4: m_pc4, sup: m_sup, vld: m_vld};
      exp_q.push_back(e);
   endtask

   // one clock of stimulus: drive after the edge, model before the next one
   task automatic cycle();
      @(posedge CLK); #2;
      PC = pc_nx; PCplus4 = pc_nx + 32'd4; Super = pc_nx[31];
      IF_Stall = (st_force < 0) ? ($urandom_range(0, 99) < st_pct) : st_force[0];
      IF_Flush = (fl_force < 0) ? ($urandom_range(0, 99) < fl_pct) : fl_force[0];
      redirect = tgt_fix_en ? tgt_fix : ($urandom & 32'h7FFF_FFF0) | ({$urandom} & 32'h8000_0000);
      imem.IMem_Ack = 1'b0;
      if (!imem.IMem_Req) mem_done = 0;
      if (imem.IMem_Req && !mem_done) begin
         if (!mem_armed) begin
            mem_cnt = (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 3));
            mem_armed = 1;
         end
         if (mem_cnt == 0) begin
            imem.IMem_Ack   = 1'b1;
            imem.IMem_Rdata = data_fix_en ? data_fix : $urandom;
            mem_done = 1; mem_armed = 0;
         end else mem_cnt--;
      end else if (!imem.IMem_Req && $urandom_range(0, 99) < spur_pct) begin
         imem.IMem_Ack   = 1'b1;
         imem.IMem_Rdata = $urandom;
      end
      @(negedge CLK); #1;
      model_step();
   endtask

   // let any transaction finish, then park in an idle stall cycle
   task automatic drain();
      st_force = 0; fl_force = 0; wait_fix = 0; spur_pct = 0;
      data_fix_en = 0; tgt_fix_en = 0;
      for (int i = 0; i < 20 && tx != 0; i++) cycle();
      st_force = 1; cycle(); st_force = 0;
   endtask

   // monitor: busy mid-cycle, registered outputs just after the edge
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK); #2;
         if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("Fetch_Busy", 32'(Fetch_Busy), 32'(e.busy));
         end
         @(posedge CLK); #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("IMem_Req", 32'(imem.IMem_Req), 32'(e.req));
            if (e.req) chk("IMem_Addr", imem.IMem_Addr, e.addr);
            chk("ID_Valid", 32'(ID_Valid), 32'(e.vld));
            chk("ID_Instr", ID_Instr, e.instr);
            chk("ID_PCplus4", ID_PCplus4, e.pc4);
            chk("ID_Super", 32'(ID_Super), 32'(e.sup));
         end
      end
   end

   initial begin
      imem.IMem_Ack = 1'b0;
      imem.IMem_Rdata = '0;
      #12;
      chk("reset IMem_Req", 32'(imem.IMem_Req), 32'd0);
      chk("reset IMem_Addr", imem.IMem_Addr, 32'd0);
      chk("reset ID_Instr", ID_Instr, NOP);
      chk("reset ID_PCplus4", ID_PCplus4, 32'd0);
      chk("reset ID_Super", 32'(ID_Super), 32'd0);
      chk("reset ID_Valid", 32'(ID_Valid), 32'd0);
      chk("reset Fetch_Busy", 32'(Fetch_Busy), 32'd0);
      @(posedge CLK); #2;
      Reset_n = 1'b1;
      model_reset();

      // zero-wait fetch at the reset vector
      drain();
      pc_nx = RST_PC; data_fix_en = 1; data_fix = 32'h8C01_0004; wait_fix = 0;
      repeat (3) cycle();

      // slow memory: three wait cycles before ack
      drain();
      wait_fix = 3;
      repeat (7) cycle();

      // flush in WAIT without ack; stale word must be dropped, redirect fetched next
      drain();
      wait_fix = 2; data_fix_en = 1; data_fix = 32'h1234_5678;
      tgt_fix_en = 1; tgt_fix = 32'h0040_0020;
      cycle();
      fl_force = 1; cycle(); fl_force = 0;
      cycle(); cycle();
      data_fix = 32'h0A0B_0C0D;
      repeat (5) cycle();

      // flush together with ack
      drain();
      cycle();
      fl_force = 1; cycle(); fl_force = 0;
      repeat (3) cycle();

      // ack under stall for two cycles, then release
      drain();
      cycle();
      st_force = 1; cycle(); cycle();
      st_force = 0; repeat (2) cycle();

      // flush while parked with stall
      drain();
      cycle();
      st_force = 1; cycle();
      fl_force = 1; cycle();
      fl_force = 0; st_force = 0; repeat (3) cycle();

      // reset in the middle of WAIT; later acks must be ignored
      drain();
      wait_fix = 6;
      cycle(); cycle();
      @(posedge CLK); #2;
      Reset_n = 1'b0; IF_Stall = 1'b1; IF_Flush = 1'b0;
      #1;
      chk("midreset IMem_Req", 32'(imem.IMem_Req), 32'd0);
      chk("midreset ID_Valid", 32'(ID_Valid), 32'd0);
      chk("midreset ID_Instr", ID_Instr, NOP);
      imem.IMem_Ack = 1'b1; imem.IMem_Rdata = 32'hBAD0_BAD0;
      @(posedge CLK); #2;
      imem.IMem_Ack = 1'b0;
      Reset_n = 1'b1;
      model_reset();
      st_force = 1; spur_pct = 100;
      repeat (2) cycle();
      spur_pct = 0;

      // random traffic
      drain();
      st_force = -1; fl_force = -1; wait_fix = -1; spur_pct = 5;
      repeat (3000) cycle();
      drain();

      @(posedge CLK); #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
